// File: rtl/md_issue_ctrl.sv
// Issue control for the HI/LO multiply/divide unit.
// Presents one-cycle E-stage ops, stalls HI/LO accesses in D while the unit works, and flags protocol errors.
module md_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_valid,
  input  logic [2:0]  d_md_op,
  input  logic        d_hilo_rd,
  input  logic        d_mt_valid,
  input  logic        d_mt_sel,
  input  logic        stall_ext,
  input  logic        flush_E,
  input  logic        md_busy,
  output logic [2:0]  MulOp_E,
  output logic [1:0]  MTHILO_E,
  output logic        stall_md,
  output logic        proto_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_t;

  state_t     state, stateNext;
  logic [3:0] sh_cnt, shCntNext;
  logic       firstBusy;
  logic       hiloAccess, advance, mdIssue, mtIssue, errSet;

  // A BUSY cycle with md_busy low is already the final one, so stalling only on
  // ARMED or md_busy lets the waiting HI/LO access go with no extra bubble.
  always_comb begin
    hiloAccess = d_md_valid | d_hilo_rd | d_mt_valid;
    stall_md   = hiloAccess & ((state == ARMED) | md_busy);
    advance    = ~stall_md & ~stall_ext;
    mdIssue    = advance & d_md_valid & ~flush_E;
    mtIssue    = advance & d_mt_valid & ~d_md_valid & ~flush_E;
  end

  always_comb begin
    stateNext = state;
    shCntNext = sh_cnt;
    errSet    = 1'b0;
    case (state)
      IDLE: ;
      ARMED: begin
        stateNext = BUSY;
        errSet    = md_busy;
      end
      BUSY: begin
        if (md_busy) begin
          if (sh_cnt == 4'd0) errSet = 1'b1;
          else                shCntNext = sh_cnt - 4'd1;
        end else begin
          stateNext = IDLE;
          errSet    = firstBusy | (sh_cnt != 4'd0);
        end
      end
      default: stateNext = IDLE;
    endcase
    // An issue is only possible from IDLE or the last BUSY cycle.
    if (mdIssue) begin
      stateNext = ARMED;
      shCntNext = d_md_op[1] ? 4'd10 : 4'd5;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sh_cnt    <= 4'd0;
      firstBusy <= 1'b0;
      MulOp_E   <= 3'b111;
      MTHILO_E  <= 2'b11;
      proto_err <= 1'b0;
      stall_cnt <= 32'd0;
    end else begin
      state     <= stateNext;
      sh_cnt    <= shCntNext;
      firstBusy <= (state == ARMED);
      MulOp_E   <= mdIssue ? d_md_op : 3'b111;
      MTHILO_E  <= mtIssue ? {1'b0, d_mt_sel} : 2'b11;
      proto_err <= proto_err | errSet;
      stall_cnt <= stall_cnt + {31'd0, stall_md};
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl; the bench drives md_busy as a hand-scripted unit model.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_md_valid;
  logic [2:0]  d_md_op;
  logic        d_hilo_rd;
  logic        d_mt_valid;
  logic        d_mt_sel;
  logic        stall_ext;
  logic        flush_E;
  logic        md_busy;
  logic [2:0]  MulOp_E;
  logic [1:0]  MTHILO_E;
  logic        stall_md;
  logic        proto_err;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .d_md_valid(d_md_valid), .d_md_op(d_md_op),
    .d_hilo_rd(d_hilo_rd), .d_mt_valid(d_mt_valid), .d_mt_sel(d_mt_sel),
    .stall_ext(stall_ext), .flush_E(flush_E), .md_busy(md_busy),
    .MulOp_E(MulOp_E), .MTHILO_E(MTHILO_E), .stall_md(stall_md),
    .proto_err(proto_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance the given number of rising edges, leaving time 1 ns past the last one.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; d_md_valid = 1'b0; d_md_op = 3'b000; d_hilo_rd = 1'b0;
    d_mt_valid = 1'b0; d_mt_sel = 1'b0; stall_ext = 1'b0; flush_E = 1'b0; md_busy = 1'b0;
    applyStimulus(2);
    checkOutput("rst_mulop", MulOp_E, 3'b111);
    checkOutput("rst_mthilo", MTHILO_E, 2'b11);
    checkOutput("rst_stall", stall_md, 1'b0);
    checkOutput("rst_err", proto_err, 1'b0);
    checkOutput("rst_cnt", stall_cnt, 32'd0);
    reset = 1'b0;

    // mult issue, then mfhi waiting in D
    d_md_valid = 1'b1; d_md_op = 3'b001; #1;
    checkOutput("mult_nostall", stall_md, 1'b0);
    applyStimulus(1);
    d_md_valid = 1'b0; d_hilo_rd = 1'b1; #1;
    checkOutput("mult_mulop", MulOp_E, 3'b001);
    checkOutput("mult_armed_stall", stall_md, 1'b1);
    applyStimulus(1);
    checkOutput("mult_mulop_once", MulOp_E, 3'b111);
    md_busy = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("mult_busy_stall", stall_md, 1'b1);
      applyStimulus(1);
    end
    md_busy = 1'b0; #1;
    checkOutput("mult_release", stall_md, 1'b0);
    applyStimulus(1);
    d_hilo_rd = 1'b0;
    checkOutput("mult_cnt", stall_cnt, 32'd6);
    checkOutput("mult_err", proto_err, 1'b0);

    // div issue, then mtlo waiting in D
    d_md_valid = 1'b1; d_md_op = 3'b011;
    applyStimulus(1);
    d_md_valid = 1'b0; d_mt_valid = 1'b1; d_mt_sel = 1'b0;
    applyStimulus(1);
    md_busy = 1'b1;
    applyStimulus(10);
    md_busy = 1'b0; #1;
    checkOutput("div_release", stall_md, 1'b0);
    checkOutput("div_mthilo_idle", MTHILO_E, 2'b11);
    applyStimulus(1);
    checkOutput("div_mtlo", MTHILO_E, 2'b00);
    d_mt_valid = 1'b0;
    applyStimulus(1);
    checkOutput("div_mtlo_once", MTHILO_E, 2'b11);
    checkOutput("div_cnt", stall_cnt, 32'd17);
    checkOutput("div_err", proto_err, 1'b0);

    // divu flushed on its issue edge
    d_md_valid = 1'b1; d_md_op = 3'b010; flush_E = 1'b1; #1;
    checkOutput("flush_nostall", stall_md, 1'b0);
    applyStimulus(1);
    d_md_valid = 1'b0; flush_E = 1'b0;
    checkOutput("flush_mulop", MulOp_E, 3'b111);
    d_hilo_rd = 1'b1; #1;
    checkOutput("flush_idle", stall_md, 1'b0);
    applyStimulus(1);
    d_hilo_rd = 1'b0;
    checkOutput("flush_cnt", stall_cnt, 32'd17);

    // external stall holds the mult in D
    d_md_valid = 1'b1; d_md_op = 3'b001; stall_ext = 1'b1;
    applyStimulus(2);
    checkOutput("ext_mulop", MulOp_E, 3'b111);
    stall_ext = 1'b0;
    applyStimulus(1);
    d_md_valid = 1'b0;
    checkOutput("ext_issue", MulOp_E, 3'b001);
    applyStimulus(1);
    md_busy = 1'b1;
    applyStimulus(5);
    md_busy = 1'b0;
    applyStimulus(1);
    checkOutput("ext_err", proto_err, 1'b0);
    checkOutput("ext_cnt", stall_cnt, 32'd17);

    // unit drops busy early on a mult
    d_md_valid = 1'b1; d_md_op = 3'b000;
    applyStimulus(1);
    d_md_valid = 1'b0;
    applyStimulus(1);
    md_busy = 1'b1;
    applyStimulus(3);
    md_busy = 1'b0;
    applyStimulus(1);
    checkOutput("early_err", proto_err, 1'b1);
    applyStimulus(3);
    checkOutput("early_sticky", proto_err, 1'b1);

    // reset in the middle of a div
    d_md_valid = 1'b1; d_md_op = 3'b011;
    applyStimulus(1);
    d_md_valid = 1'b0;
    applyStimulus(1);
    md_busy = 1'b1;
    applyStimulus(2);
    reset = 1'b1; md_busy = 1'b0;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("rb_mulop", MulOp_E, 3'b111);
    checkOutput("rb_mthilo", MTHILO_E, 2'b11);
    checkOutput("rb_err", proto_err, 1'b0);
    checkOutput("rb_cnt", stall_cnt, 32'd0);
    d_hilo_rd = 1'b1; #1;
    checkOutput("rb_nostall", stall_md, 1'b0);
    applyStimulus(1);
    d_hilo_rd = 1'b0;
    checkOutput("rb_cnt_after", stall_cnt, 32'd0);

    // reset wins over a same-edge issue
    reset = 1'b1; d_md_valid = 1'b1; d_md_op = 3'b001;
    applyStimulus(1);
    reset = 1'b0; d_md_valid = 1'b0;
    checkOutput("rp_mulop", MulOp_E, 3'b111);
    d_hilo_rd = 1'b1; #1;
    checkOutput("rp_idle", stall_md, 1'b0);
    d_hilo_rd = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
